// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // Controller states: waiting, shifting one bit per clock, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for an n-bit operand; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Difference bit and borrow generation for a single bit position.
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, one bit per clock
// through a single full-subtractor cell. start/done handshake: start is taken
// only in IDLE or DONE; done is a one-cycle pulse marking diff/bout valid, and
// diff/bout hold their value until the next completion.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           br_q, br_d;
    logic           bout_q, bout_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cell_d;
    logic           cell_bout;

    // The one shared arithmetic cell always looks at the operand LSBs.
    full_subtractor u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    // Next-state and datapath update: accept, shift one bit, or publish result.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d   = {1'b0, a_q[N-1:1]};
                b_d   = {1'b0, b_q[N-1:1]};
                br_d  = cell_bout;
                res_d = {cell_d, res_q[N-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: the freshly shifted word is the full result.
                    diff_d  = {cell_d, res_q[N-1:1]};
                    bout_d  = cell_bout;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All state and datapath registers; reset clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status flags decode straight from the state register, so they are glitch-free.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        diff = diff_q;
        bout = bout_q;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; the sequential counterpart of the parallel ripple-carry adder.
- Computes diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell.
- Start/done handshake; a shared-datapath arithmetic unit for area-constrained datapaths and as a cross-check reference for the parallel adder family.

Parameters:
- N, 8, operand/result width in bits; legal N >= 2.

Ports:
- clk    input   1   clock, rising edge
- rst    input   1   asynchronous, active-high reset
- start  input   1   request; sampled on rising clk; accepted only in IDLE or DONE
- a      input   N   minuend; captured on accepted start
- b      input   N   subtrahend; captured on accepted start
- bin    input   1   borrow-in; captured on accepted start
- busy   output  1   high while in RUN
- done   output  1   one-cycle pulse; result valid
- diff   output  N   result (a - b - bin) mod 2^N; held until next completion
- bout   output  1   borrow-out: 1 when a < b + bin (unsigned); held with diff

Behaviour:
- Reset (async assert, any state):
  - state = IDLE; busy = 0, done = 0, diff = 0, bout = 0.
  - Internal operand registers, shift register, borrow and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at an edge: latch a, b into shift registers; borrow register = bin; bit counter = 0; go to RUN.
  - start = 0: stay.
- RUN, one bit per edge:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d shifts into the MSB of the result shift register; operand registers shift right; counter increments.
  - Transition rule: the edge processing bit N-1 (counter == N-1) transfers the full result to diff, the final borrow to bout, asserts done, and goes to DONE.
  - start is ignored in RUN; operands are not re-latched.
- DONE (exactly one cycle):
  - done = 1.
  - start = 1: accepted exactly as from IDLE (back-to-back); go to RUN.
  - Otherwise: go to IDLE.
  - done deasserts on the next edge in either case.
- Latency: start sampled at edge k, processing at edges k+1 .. k+N, done high in the cycle after edge k+N.
  - Throughput: one result per N+1 cycles with back-to-back starts.
- busy = (state == RUN), registered; first high in the cycle after the accepted start.
- diff/bout update only at completion and remain stable through RUN of a subsequent operation.
- Arithmetic: unsigned, modulo 2^N; bin = 1 with a == b gives diff = all-ones, bout = 1.
- Counter width: $clog2(N); no wrap beyond N-1 is reachable.
- Reset asserted mid-RUN: operation abandoned; no done pulse; outputs zero after reset; first start after deassertion behaves as from IDLE.
- Operand inputs may change freely after the accepting edge without affecting the result.

Decomposition:
- Package serial_sub_pkg:
  - typedef enum logic [1:0] state_t {IDLE, RUN, DONE}.
  - Localparam helper for counter width.
- Sub-module full_subtractor: combinational 1-bit cell; inputs a, b, bin; outputs d, bout. Instantiated once in the datapath.
- Top holds FSM, counter, operand/result shift registers, output registers.

Test Plan:
- Basic subtraction. a=8'h50, b=8'h20, bin=0, start pulse -> busy high 8 cycles; done one cycle; diff=8'h30, bout=0. Check done exactly 8 cycles after the accepting edge.
- Underflow. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1. Also a=8'h80, b=8'h80, bin=1 -> diff=8'hFF, bout=1.
- Busy lockout. Start a=8'hA5, b=8'h5A, bin=0; at cycle 3 pulse start with a=8'h01, b=8'h01 -> ignored; diff=8'h4B, bout=0; only one done pulse.
- Back-to-back. Assert start during the DONE cycle with a=8'hFF, b=8'h0F, bin=1 -> second done 9 cycles after the first; diff=8'hEF, bout=0. First result held on diff until the second completion.
- Reset mid-operation. Start a=8'h10, b=8'h01; assert rst asynchronously at cycle 4 -> busy/done/diff/bout = 0 immediately; no done pulse. New start a=8'h03, b=8'h05, bin=0 -> diff=8'hFE, bout=1.
- Random regression. 200 random a, b, bin, N=8 and N=16 -> diff == (a-b-bin) mod 2^N; bout == (a < b+bin).
